// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the MIPS32 register scoreboard.
// Register 0 is the hardwired-zero register and never tracks pending writes.
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter.
// Saturates at both ends and clears synchronously; clear wins over inc/dec.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = $bits(cnt_t)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic at_max,
  output logic is_one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && nonzero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nonzero = (cnt != '0);
  assign at_max  = (cnt == '1);
  assign is_one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight register-file writes per register
// and stalls decode when a source is pending or a destination counter is full.
module reg_scoreboard #(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_scoreboard_pkg::ADDR_W,
  parameter int CNT_W    = reg_scoreboard_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_wr_en,
  input  logic [ADDR_W-1:0]   issue_wr_addr,
  input  logic                src_use1,
  input  logic [ADDR_W-1:0]   src_addr1,
  input  logic                src_use2,
  input  logic [ADDR_W-1:0]   src_addr2,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                underflow_err
);

  import reg_scoreboard_pkg::REG_ZERO;

  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] at_max;
  logic [NUM_REGS-1:0] is_one;
  logic [NUM_REGS-1:0] pend;
  logic                haz1;
  logic                haz2;
  logic                full;
  logic                acc;

  // A last pending write committing this cycle is already visible to readers,
  // because the register file writes on the falling edge.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign nonzero[r] = 1'b0;
      assign at_max[r]  = 1'b0;
      assign is_one[r]  = 1'b0;
      assign pend[r]    = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec;

      assign inc = acc && issue_wr_en && (issue_wr_addr == ADDR_W'(r));
      assign dec = wb_en && (wb_addr == ADDR_W'(r)) && nonzero[r];

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .dec     (dec),
        .clr     (flush),
        .nonzero (nonzero[r]),
        .at_max  (at_max[r]),
        .is_one  (is_one[r])
      );

      assign pend[r] = nonzero[r] && !(wb_en && (wb_addr == ADDR_W'(r)) && is_one[r]);
    end
  end

  always_comb begin
    haz1  = src_use1 && (src_addr1 != REG_ZERO) && pend[src_addr1];
    haz2  = src_use2 && (src_addr2 != REG_ZERO) && pend[src_addr2];
    full  = issue_wr_en && (issue_wr_addr != REG_ZERO) && at_max[issue_wr_addr]
            && !(wb_en && (wb_addr == issue_wr_addr));
    stall = issue_valid && (haz1 || haz2 || full);
    acc   = issue_valid && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err <= 1'b0;
    end else if (wb_en && (wb_addr != REG_ZERO) && !nonzero[wb_addr]) begin
      underflow_err <= 1'b1;
    end
  end

  assign busy_vec = nonzero;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: expectations are queued as
// stimulus is driven and popped when the corresponding output is sampled.
module tb_reg_scoreboard;

  localparam int KIND_STALL = 0;
  localparam int KIND_BUSY  = 1;
  localparam int KIND_UF    = 2;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_wr_en;
  logic [4:0]  issue_wr_addr;
  logic        src_use1;
  logic [4:0]  src_addr1;
  logic        src_use2;
  logic [4:0]  src_addr2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        stall;
  logic [31:0] busy_vec;
  logic        underflow_err;

  exp_t sbq[$];
  int   compared;
  int   mismatched;

  reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_wr_en   (issue_wr_en),
    .issue_wr_addr (issue_wr_addr),
    .src_use1      (src_use1),
    .src_addr1     (src_addr1),
    .src_use2      (src_use2),
    .src_addr2     (src_addr2),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .flush         (flush),
    .stall         (stall),
    .busy_vec      (busy_vec),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    issue_valid   = 1'b0;
    issue_wr_en   = 1'b0;
    issue_wr_addr = '0;
    src_use1      = 1'b0;
    src_addr1     = '0;
    src_use2      = 1'b0;
    src_addr2     = '0;
    wb_en         = 1'b0;
    wb_addr       = '0;
    flush         = 1'b0;
  endtask

  task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL empty_queue observed=none expected=entry");
    end else begin
      e = sbq.pop_front();
      case (e.kind)
        KIND_STALL: obs = {31'b0, stall};
        KIND_BUSY:  obs = busy_vec;
        default:    obs = {31'b0, underflow_err};
      endcase
      assert (obs === e.val) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one decode/writeback cycle at the falling edge and check stall.
  task automatic applyStimulus(input string tag,
                               input logic iv, input logic iwe, input logic [4:0] iwa,
                               input logic u1, input logic [4:0] a1,
                               input logic u2, input logic [4:0] a2,
                               input logic we, input logic [4:0] wa,
                               input logic fl, input logic exp_stall);
    @(negedge clk);
    issue_valid   = iv;
    issue_wr_en   = iwe;
    issue_wr_addr = iwa;
    src_use1      = u1;
    src_addr1     = a1;
    src_use2      = u2;
    src_addr2     = a2;
    wb_en         = we;
    wb_addr       = wa;
    flush         = fl;
    expect_val({tag, "_stall"}, KIND_STALL, {31'b0, exp_stall});
    #1;
    checkOutput();
  endtask

  // Let the edge happen, then check registered state.
  task automatic checkState(input string tag, input logic [31:0] exp_busy, input logic exp_uf);
    @(posedge clk);
    #1;
    clearInputs();
    expect_val({tag, "_busy"}, KIND_BUSY, exp_busy);
    expect_val({tag, "_uf"}, KIND_UF, {31'b0, exp_uf});
    checkOutput();
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue_valid = 1'b1; src_use1 = 1'b1; src_addr1 = 5'd5;
    expect_val("reset_stall", KIND_STALL, 32'd0);
    expect_val("reset_busy", KIND_BUSY, 32'd0);
    expect_val("reset_uf", KIND_UF, 32'd0);
    checkOutput(); checkOutput(); checkOutput();
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;

    // r5: write, stalled reader, bypassed reader with writeback
    applyStimulus("r5_wr",    1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r5_wr", 32'h0000_0020, 0);
    applyStimulus("r5_rd",    1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1);
    checkState("r5_rd", 32'h0000_0020, 0);
    applyStimulus("r5_rd_wb", 1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0);
    checkState("r5_rd_wb", 32'h0000_0000, 0);

    // r0 is ignored entirely
    applyStimulus("r0_wr",    1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkState("r0_wr", 32'h0, 0);
    applyStimulus("r0_rd_wb", 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    checkState("r0_rd_wb", 32'h0, 0);

    // r7: fill to max, full stall, full bypass with writeback, drain
    applyStimulus("r7_w1", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r7_w1", 32'h0000_0080, 0);
    applyStimulus("r7_w2", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r7_w2", 32'h0000_0080, 0);
    applyStimulus("r7_w3", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r7_w3", 32'h0000_0080, 0);
    applyStimulus("r7_full",    1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    checkState("r7_full", 32'h0000_0080, 0);
    applyStimulus("r7_full_wb", 1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
    checkState("r7_full_wb", 32'h0000_0080, 0);
    applyStimulus("r7_still_full", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    checkState("r7_still_full", 32'h0000_0080, 0);
    applyStimulus("r7_d1", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    checkState("r7_d1", 32'h0000_0080, 0);
    applyStimulus("r7_d2", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    checkState("r7_d2", 32'h0000_0080, 0);
    applyStimulus("r7_d3", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    checkState("r7_d3", 32'h0000_0000, 0);

    // r9: inc and dec together hold the count at 1
    applyStimulus("r9_w1",     1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r9_w1", 32'h0000_0200, 0);
    applyStimulus("r9_inc_dec", 1, 1, 9, 1, 9, 0, 0, 1, 9, 0, 0);
    checkState("r9_inc_dec", 32'h0000_0200, 0);
    applyStimulus("r9_rd",     1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1);
    checkState("r9_rd", 32'h0000_0200, 0);
    applyStimulus("r9_drain",  0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    checkState("r9_drain", 32'h0000_0000, 0);

    // Underflow is sticky
    applyStimulus("r12_uf", 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    checkState("r12_uf", 32'h0, 1);
    applyStimulus("r3_w", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r3_w", 32'h0000_0008, 1);
    applyStimulus("r4_w", 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r4_w", 32'h0000_0018, 1);

    // Flush: stall still uses pre-flush counters; accepted issue is discarded
    applyStimulus("flush_rd", 1, 1, 3, 1, 4, 0, 0, 0, 0, 1, 1);
    checkState("flush_rd", 32'h0, 1);
    applyStimulus("r3_w2", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r3_w2", 32'h0000_0008, 1);
    applyStimulus("flush_iss", 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    checkState("flush_iss", 32'h0, 1);

    // Asynchronous reset mid-run
    applyStimulus("r6_w", 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("r6_w", 32'h0000_0040, 1);
    #2;
    rst_n = 1'b0;
    #1;
    issue_valid = 1'b1; src_use1 = 1'b1; src_addr1 = 5'd6;
    expect_val("async_rst_busy", KIND_BUSY, 32'h0);
    expect_val("async_rst_uf", KIND_UF, 32'h0);
    expect_val("async_rst_stall", KIND_STALL, 32'h0);
    checkOutput(); checkOutput(); checkOutput();
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst_rd", 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
    checkState("post_rst_rd", 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
